// File: rtl/sudoku_board_reader.sv
// Streams a stored NxN board out row-major as {sof, eol, 2'b00, value} bytes over valid/ready.
// Latency: one cycle from address to beat; backpressure holds the beat and the address stable.
module sudoku_board_reader #(
    parameter int N       = 9,
    parameter int VAL_W   = 4,
    parameter int MAX_VAL = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [3:0]       rd_row,
    output logic [3:0]       rd_col,
    input  logic [VAL_W-1:0] rd_data,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    localparam logic [3:0] LAST = 4'(N - 1);

    state_t     state_q, state_d;
    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic [7:0] dat_q, dat_d;
    logic       vld_q, vld_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       load;
    logic       bad;
    logic [3:0] val;

    always_comb begin
        load = !vld_q || out_ready;
        bad  = (32'(rd_data) > 32'(MAX_VAL));
        val  = bad ? 4'hF : rd_data[3:0];
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dat_d   = dat_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                // the done cycle still counts as busy for start purposes
                if (start && !done_q) begin
                    state_d = S_STREAM;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                end
            end
            S_STREAM: begin
                if (load) begin
                    dat_d = {(row_q == 4'd0) && (col_q == 4'd0), col_q == LAST, 2'b00, val};
                    vld_d = 1'b1;
                    if (bad) err_d = 1'b1;
                    if (col_q == LAST) begin
                        if (row_q == LAST) begin
                            state_d = S_DRAIN;
                        end else begin
                            col_d = 4'd0;
                            row_d = row_q + 4'd1;
                        end
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            dat_q   <= 8'd0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rd_row    = row_q;
    assign rd_col    = col_q;
    assign out_data  = dat_q;
    assign out_valid = vld_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sudoku_board_reader.sv
// Bench for sudoku_board_reader: random boards and consumer stalls against a row-major board model.
module tb_sudoku_board_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] rd_row, rd_col;
    logic [3:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid, busy, done, err;

    sudoku_board_reader #(.N(9), .VAL_W(4), .MAX_VAL(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [3:0] board [9][9];

    always_comb begin
        rd_data = 4'd0;
        if (int'(rd_row) < 9 && int'(rd_col) < 9) rd_data = board[int'(rd_row)][int'(rd_col)];
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    logic       got_err[$];
    logic [7:0] expq[$];
    logic       exp_err[$];
    logic [7:0] st_dat[$];
    logic [3:0] st_row[$];
    logic [3:0] st_col[$];
    int         done_cnt, done_cyc;
    bit         timed_out;
    logic       post_busy;

    // mode 0: (r+c)%10, mode 1: random legal, mode 2: random with occasional illegal values
    task automatic fill_board(input int mode);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
                if (mode == 0)      board[r][c] = 4'((r + c) % 10);
                else if (mode == 1) board[r][c] = 4'($urandom_range(9));
                else                board[r][c] = ($urandom_range(19) == 0) ? 4'($urandom_range(15, 10))
                                                                            : 4'($urandom_range(9));
            end
    endtask

    function automatic void build_model();
        bit seen_bad;
        seen_bad = 0;
        expq.delete();
        exp_err.delete();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
                int v;
                v = int'(board[r][c]);
                if (v > 9) begin
                    seen_bad = 1;
                    v = 15;
                end
                expq.push_back(8'((r == 0 && c == 0) * 128 + (c == 8) * 64 + v));
                exp_err.push_back(seen_bad);
            end
    endfunction

    task automatic start_readout();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Drives the consumer until done (or abort point); records accepted beats and err alongside each.
    task automatic capture(input int ready_pct, input int stall_at, input int stall_len,
                           input int start_at, input int abort_at, input bit start_in_done);
        int  cyc, stalled;
        bit  seen_done, start_fired, stall_now;
        cyc = 0; stalled = 0; seen_done = 0; start_fired = 0;
        got.delete(); got_err.delete(); st_dat.delete(); st_row.delete(); st_col.delete();
        done_cnt = 0; done_cyc = -1; timed_out = 0;
        while (!seen_done) begin
            @(posedge clk); #1;
            cyc++;
            if (abort_at >= 0 && got.size() == abort_at) return;
            start = 1'b0;
            if (start_at >= 0 && got.size() == start_at && !start_fired) begin
                start = 1'b1;
                start_fired = 1;
            end
            stall_now = 0;
            if (stall_at >= 0 && got.size() == stall_at && out_valid && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
                stall_now = 1;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            @(negedge clk);
            if (stall_now) begin
                st_dat.push_back(out_data);
                st_row.push_back(rd_row);
                st_col.push_back(rd_col);
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                got_err.push_back(err);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                seen_done = 1;
            end
            if (cyc >= 2000) begin
                timed_out = 1;
                break;
            end
        end
        start = start_in_done;
        out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        post_busy = busy;
        if (done) done_cnt++;
        @(negedge clk);
        if (done) done_cnt++;
    endtask

    task automatic test_reset();
        start = 1'b1;
        out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_row, rd_col, out_data, out_valid, busy, done, err} !== 20'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 0", {rd_row, rd_col, out_data, out_valid, busy, done, err});
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rd_row, rd_col, out_data, out_valid, busy, done, err} !== 20'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h expected 0", i,
                         {rd_row, rd_col, out_data, out_valid, busy, done, err});
            end
        end
    endtask

    task automatic test_full_stream();
        fill_board(0);
        build_model();
        start_readout();
        capture(100, -1, 0, -1, -1, 1'b1);
        checks++;
        if (timed_out || got.size() != 81) begin
            errors++;
            $display("FAIL full_count: got %0d beats (timeout %0d) expected 81", got.size(), timed_out);
        end
        for (int k = 0; k < got.size() && k < 81; k++) begin
            checks++;
            if (got[k] !== expq[k]) begin
                errors++;
                $display("FAIL full_beat %0d: got %h expected %h", k, got[k], expq[k]);
            end
        end
        checks++;
        if (got.size() == 81 && (got[0] !== 8'h80 || got[8] !== 8'h48 || got[80] !== 8'h46)) begin
            errors++;
            $display("FAIL full_landmarks: got %h %h %h expected 80 48 46", got[0], got[8], got[80]);
        end
        checks++;
        if (done_cyc != 82 || done_cnt != 1) begin
            errors++;
            $display("FAIL full_done: got cycle %0d count %0d expected cycle 82 count 1", done_cyc, done_cnt);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL full_err: got %b expected 0", err);
        end
        checks++;
        if (post_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_cycle: busy got %b expected 0", post_busy);
        end
    endtask

    task automatic test_backpressure();
        fill_board(0);
        build_model();
        start_readout();
        capture(100, 10, 3, -1, -1, 1'b0);
        checks++;
        if (st_dat.size() != 3) begin
            errors++;
            $display("FAIL bp_stall_len: got %0d stalled cycles expected 3", st_dat.size());
        end
        for (int i = 0; i < st_dat.size(); i++) begin
            checks++;
            if (st_dat[i] !== 8'h02 || st_row[i] !== 4'd1 || st_col[i] !== 4'd2) begin
                errors++;
                $display("FAIL bp_hold %0d: got dat %h row %0d col %0d expected 02 1 2",
                         i, st_dat[i], st_row[i], st_col[i]);
            end
        end
        checks++;
        if (timed_out || got.size() != 81 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_count: got %0d beats, %0d done expected 81, 1", got.size(), done_cnt);
        end
        for (int k = 0; k < got.size() && k < 81; k++) begin
            checks++;
            if (got[k] !== expq[k]) begin
                errors++;
                $display("FAIL bp_beat %0d: got %h expected %h", k, got[k], expq[k]);
            end
        end
    endtask

    task automatic test_invalid_cell();
        fill_board(0);
        board[4][4] = 4'd12;
        build_model();
        start_readout();
        capture(100, -1, 0, -1, -1, 1'b0);
        checks++;
        if (got.size() != 81 || got[40] !== 8'h0F) begin
            errors++;
            $display("FAIL inv_beat40: got %h (size %0d) expected 0f", (got.size() > 40) ? got[40] : 8'hxx, got.size());
        end
        for (int k = 0; k < got_err.size() && k < 81; k++) begin
            checks++;
            if (got_err[k] !== exp_err[k]) begin
                errors++;
                $display("FAIL inv_err_trail beat %0d: got %b expected %b", k, got_err[k], exp_err[k]);
            end
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL inv_err_sticky: got %b expected 1", err);
        end
        fill_board(1);
        build_model();
        start_readout();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL inv_err_clear: got err %b busy %b expected 0 1", err, busy);
        end
        capture(100, -1, 0, -1, -1, 1'b0);
        checks++;
        if (err !== 1'b0 || got.size() != 81) begin
            errors++;
            $display("FAIL inv_clean_run: got err %b beats %0d expected 0 81", err, got.size());
        end
    endtask

    task automatic test_start_while_busy();
        fill_board(1);
        build_model();
        start_readout();
        capture(80, -1, 0, 30, -1, 1'b0);
        checks++;
        if (timed_out || got.size() != 81 || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start_count: got %0d beats, %0d done expected 81, 1", got.size(), done_cnt);
        end
        for (int k = 0; k < got.size() && k < 81; k++) begin
            checks++;
            if (got[k] !== expq[k]) begin
                errors++;
                $display("FAIL busy_start_beat %0d: got %h expected %h", k, got[k], expq[k]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        fill_board(1);
        build_model();
        start_readout();
        capture(100, -1, 0, -1, 40, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_row !== 4'd0 || rd_col !== 4'd0) begin
            errors++;
            $display("FAIL midreset_abort: got vld %b busy %b done %b row %0d col %0d expected all 0",
                     out_valid, busy, done, rd_row, rd_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_done cyc %0d: got done %b busy %b expected 0 0", i, done, busy);
            end
        end
        start_readout();
        capture(100, -1, 0, -1, -1, 1'b0);
        checks++;
        if (got.size() != 81 || got[0][7] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart: got %0d beats first %h expected 81 with sof",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        for (int k = 0; k < got.size() && k < 81; k++) begin
            checks++;
            if (got[k] !== expq[k]) begin
                errors++;
                $display("FAIL midreset_beat %0d: got %h expected %h", k, got[k], expq[k]);
            end
        end
    endtask

    task automatic test_random_boards();
        for (int round = 0; round < 3; round++) begin
            fill_board(2);
            build_model();
            start_readout();
            capture(int'($urandom_range(100, 50)), -1, 0, -1, -1, 1'b0);
            checks++;
            if (timed_out || got.size() != 81 || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d beats, %0d done expected 81, 1", round, got.size(), done_cnt);
            end
            for (int k = 0; k < got.size() && k < 81; k++) begin
                checks++;
                if (got[k] !== expq[k] || got_err[k] !== exp_err[k]) begin
                    errors++;
                    $display("FAIL rand%0d_beat %0d: got %h err %b expected %h err %b",
                             round, k, got[k], got_err[k], expq[k], exp_err[k]);
                end
            end
            checks++;
            if (err !== exp_err[80]) begin
                errors++;
                $display("FAIL rand%0d_final_err: got %b expected %b", round, err, exp_err[80]);
            end
        end
    endtask

    initial begin
        fill_board(0);
        test_reset();
        test_full_stream();
        test_backpressure();
        test_invalid_cell();
        test_start_while_busy();
        test_reset_mid_stream();
        test_random_boards();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sudoku_board_reader.md
Name: sudoku_board_reader

Overview:
Streams a stored 9x9 sudoku board out of the board register array, in row-major order, as a byte stream with valid/ready handshake. This is the readout counterpart of the nibble-wise board loader: the loader writes cells from ui_in, and this block reads them back for uo_out/uio_out transmission or for a downstream checker. It drives a row/column read address into the board array and registers the combinationally returned cell value. It also flags out-of-range cell values.

Parameters:
N, 9, board dimension (rows = columns = N); number of beats = N*N
VAL_W, 4, cell value width in bits (stored cells are 5 bits; the upper bits are dropped by the instantiating level)
MAX_VAL, 9, largest legal cell value; 0 means an empty cell

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a full-board readout; sampled only in IDLE
rd_row  output  4  board read row address, 0..N-1
rd_col  output  4  board read column address, 0..N-1
rd_data  input  VAL_W  cell value at (rd_row, rd_col), combinational same-cycle read
out_data  output  8  {sof, eol, 2'b00, value[3:0]}
out_valid  output  1  out_data holds a beat
out_ready  input  1  consumer accepts a beat when out_valid & out_ready at a clk edge
busy  output  1  readout in progress
done  output  1  one-cycle pulse after the last beat is accepted
err  output  1  sticky: at least one cell > MAX_VAL in the current/last readout

Behaviour:
- Reset (async, rst_n=0): state IDLE; rd_row=rd_col=0; out_data=0; out_valid=0; busy=0; done=0; err=0. Reset mid-readout aborts immediately and does not drive done.
- States: IDLE, STREAM, DRAIN.
- IDLE: if start=1 at edge E0, go to STREAM, busy=1, err cleared, rd_row=rd_col=0.
- STREAM: the load condition is (!out_valid | out_ready). On a load edge:
  - out_data captures rd_data; out_valid=1.
  - sof=1 only for cell (0,0); eol=1 when rd_col==N-1.
  - If rd_data > MAX_VAL, the emitted value is 4'hF and err is set.
  - The address advances column-first: col N-1 wraps to 0 and row increments.
  - Loading cell (N-1,N-1) moves the state to DRAIN. The address then stays at (N-1,N-1).
- DRAIN: when the final beat is accepted, out_valid=0, busy=0, done=1 for one cycle, and the state returns to IDLE.
- Backpressure: while out_valid=1 and out_ready=0, out_data and the address hold stable and nothing is loaded.
- Throughput: with out_ready held at 1 there is one beat per cycle.
  - Beat k loads at E(k+1) and is accepted at E(k+2).
  - The last beat (k=80) is accepted at E82; done is high in the cycle after E82.
- start while busy=1 is ignored, including in DRAIN and in the done cycle. A start in the cycle after done is accepted.
- out_ready while out_valid=0 has no effect.
- err stays set after done until the next accepted start.
- The board array is not written by this block. Concurrent writes by the loader during a readout are a system-level hazard and are outside this block's scope. Each beat reflects the array contents at that beat's load edge.
- rd_row and rd_col never exceed N-1.

Test Plan:
- Reset: hold rst_n=0 with start=1 and out_ready=1 -> all outputs are 0. After release with start=0 for 5 cycles, the outputs stay 0.
- Full stream, out_ready=1, board cell(r,c)=(r+c)%10 -> 81 beats in order.
  - Beat 0 = 8'h80 (sof=1, value 0).
  - Beat 8 = 8'h48 (eol=1, value 8).
  - Beat 80 = 8'h46 (eol=1, value 16%10=6).
  - done pulses exactly once, in the cycle after E82; err=0.
- Backpressure: drop out_ready for 3 cycles while beat 10 (cell (1,1)) is valid -> out_data stays 8'h02 and rd_row/rd_col stay (1,2). No beat is lost or duplicated; the total is still 81 beats.
- Invalid cell: cell(4,4)=12 -> beat 40 = 8'h0F and err=1 from that edge onward. err is still 1 after done and clears on the next accepted start.
- start pulse at beat 30 while busy -> no restart; the sequence continues with cell (3,4) and completes with 81 beats.
- Reset at beat 40 mid-stream -> out_valid=0, busy=0, no done pulse. A new start then begins at (0,0) with sof=1.
